// File: rtl/apb3_csr_bank.sv
// APB3 control/status register slave: RW control words, RO status words, pulse strobes,
// W1C interrupt status with enable mask, and PSLVERROR on bad accesses.
module apb3_csr_bank #(
  parameter int                     ADDR_WIDTH = 12,
  parameter int                     DATA_WIDTH = 32,
  parameter int                     NUM_RW     = 8,
  parameter int                     NUM_RO     = 8,
  parameter int                     NUM_IRQ    = 8,
  parameter logic [31:0]            ID_VALUE   = 32'hABCD_5678,
  parameter logic [NUM_RW*32-1:0]   RW_RESET   = '0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [31:0]             PWDATA,
  output logic                    PREADY,
  output logic [31:0]             PRDATA,
  output logic                    PSLVERROR,
  output logic [NUM_RW*32-1:0]    ctrl_out,
  input  logic [NUM_RO*32-1:0]    status_in,
  output logic [31:0]             pulse_out,
  input  logic [NUM_IRQ-1:0]      irq_event,
  output logic                    irq
);

  localparam int unsigned RW_N   = NUM_RW;
  localparam int unsigned P_IDX  = NUM_RW + NUM_RO;
  localparam int unsigned STAT_W = P_IDX + 1;
  localparam int unsigned EN_W   = P_IDX + 2;
  localparam int unsigned ID_W   = P_IDX + 3;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  if (DATA_WIDTH != 32) begin : g_bad_dw
    $error("apb3_csr_bank: DATA_WIDTH must be 32");
  end
  if (ADDR_WIDTH < 4) begin : g_bad_aw
    $error("apb3_csr_bank: ADDR_WIDTH must be at least 4");
  end
  if (NUM_IRQ < 1 || NUM_IRQ > 32) begin : g_bad_irq
    $error("apb3_csr_bank: NUM_IRQ must be in 1..32");
  end
  if ((NUM_RW + NUM_RO + 4) > (2 ** (ADDR_WIDTH - 2))) begin : g_bad_map
    $error("apb3_csr_bank: register map does not fit the address space");
  end

  logic [1:0]          state;
  logic [31:0]         ctrl_q [NUM_RW];
  logic [NUM_IRQ-1:0]  irq_stat;
  logic [NUM_IRQ-1:0]  irq_en;
  logic [NUM_IRQ-1:0]  irq_clr;
  int unsigned         widx;
  logic                err;
  logic [31:0]         rdata;
  logic                access;
  logic                wr_en;

  assign widx   = 32'(PADDR[ADDR_WIDTH-1:2]);
  assign access = (state == WAIT) && PSEL;
  assign wr_en  = access && PWRITE && !err;
  assign PREADY = (state == DONE);

  // Read mux is built as OR chains over one-hot word hits so every select is constant.
  logic [31:0] rw_chain [NUM_RW+1];
  logic [31:0] ro_chain [NUM_RO+1];
  assign rw_chain[0] = '0;
  assign ro_chain[0] = '0;

  for (genvar g = 0; g < NUM_RW; g++) begin : g_rw
    assign rw_chain[g+1] = rw_chain[g] | ((widx == g) ? ctrl_q[g] : '0);
    assign ctrl_out[32*g +: 32] = ctrl_q[g];

    always_ff @(posedge clk) begin
      if (!resetn) begin
        ctrl_q[g] <= RW_RESET[32*g +: 32];
      end else if (wr_en && widx == g) begin
        ctrl_q[g] <= PWDATA;
      end
    end
  end

  for (genvar g = 0; g < NUM_RO; g++) begin : g_ro
    assign ro_chain[g+1] = ro_chain[g] |
                           ((widx == RW_N + g) ? status_in[32*g +: 32] : '0);
  end

  always_comb begin
    err = (PADDR[1:0] != 2'b00) || (widx > ID_W) ||
          (PWRITE && (((widx >= RW_N) && (widx < P_IDX)) || (widx == ID_W)));
    rdata = '0;
    if (widx < RW_N) begin
      rdata = rw_chain[NUM_RW];
    end else if (widx < P_IDX) begin
      rdata = ro_chain[NUM_RO];
    end else if (widx == STAT_W) begin
      rdata = 32'(irq_stat);
    end else if (widx == EN_W) begin
      rdata = 32'(irq_en);
    end else if (widx == ID_W) begin
      rdata = ID_VALUE;
    end
    if (err || PWRITE) begin
      rdata = '0;
    end
  end

  assign irq_clr = (wr_en && widx == STAT_W) ? PWDATA[NUM_IRQ-1:0] : '0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      PRDATA    <= '0;
      PSLVERROR <= 1'b0;
      pulse_out <= '0;
      irq_stat  <= '0;
      irq_en    <= '0;
      irq       <= 1'b0;
    end else begin
      case (state)
        IDLE:    state <= (PSEL && !PENABLE) ? SETUP : IDLE;
        SETUP:   state <= (PSEL && PENABLE) ? WAIT : IDLE;
        WAIT:    state <= PSEL ? DONE : IDLE;
        default: state <= IDLE;
      endcase
      PRDATA    <= access ? rdata : '0;
      PSLVERROR <= access ? err : 1'b0;
      pulse_out <= (wr_en && widx == P_IDX) ? PWDATA : '0;
      // A clear is applied before the new events are merged, so a same-cycle event survives.
      irq_stat  <= (irq_stat & ~irq_clr) | irq_event;
      if (wr_en && widx == EN_W) begin
        irq_en <= PWDATA[NUM_IRQ-1:0];
      end
      irq <= |(irq_stat & irq_en);
    end
  end

endmodule

// File: tb/tb_apb3_csr_bank.sv
// Randomised scoreboard bench for apb3_csr_bank against a behavioural register-map model.
module tb_apb3_csr_bank;
  localparam int AW   = 12;
  localparam int NRW  = 8;
  localparam int NRO  = 8;
  localparam int NIRQ = 8;
  localparam int unsigned P = NRW + NRO;
  localparam logic [31:0] ID = 32'hABCD_5678;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [AW-1:0]     PADDR = '0;
  logic              PSEL = 1'b0;
  logic              PENABLE = 1'b0;
  logic              PWRITE = 1'b0;
  logic [31:0]       PWDATA = '0;
  logic              PREADY;
  logic [31:0]       PRDATA;
  logic              PSLVERROR;
  logic [NRW*32-1:0] ctrl_out;
  logic [NRO*32-1:0] status_in = '0;
  logic [31:0]       pulse_out;
  logic [NIRQ-1:0]   irq_event = '0;
  logic              irq;

  always #5 clk = ~clk;

  apb3_csr_bank #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(32), .NUM_RW(NRW), .NUM_RO(NRO),
    .NUM_IRQ(NIRQ), .ID_VALUE(ID), .RW_RESET('0)
  ) dut (
    .clk(clk), .resetn(resetn), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA),
    .PSLVERROR(PSLVERROR), .ctrl_out(ctrl_out), .status_in(status_in),
    .pulse_out(pulse_out), .irq_event(irq_event), .irq(irq)
  );

  typedef struct packed { logic [31:0] d; logic e; } resp_t;
  resp_t           expq [$];
  logic [31:0]     ctrl_m [NRW];
  logic [31:0]     stat_in_m [NRO];
  logic [NIRQ-1:0] stat_m;
  logic [NIRQ-1:0] en_m;
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", nm, got, exp);
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NRW; k++) ctrl_m[k] = '0;
    stat_m = '0;
    en_m   = '0;
  endfunction

  // Register-map semantics: returns the bus response and applies the write effect.
  function automatic void model_access(input logic [AW-1:0] a, input logic wr,
                                       input logic [31:0] wd, output logic err,
                                       output logic [31:0] rd, output logic [31:0] pulse);
    int unsigned w;
    w = int'(a) / 4;
    err = (a % 4 != 0) || (w > P + 3) || (wr && ((w >= NRW && w < P) || w == P + 3));
    rd = '0;
    pulse = '0;
    if (!err && !wr) begin
      if (w < NRW)         rd = ctrl_m[w];
      else if (w < P)      rd = stat_in_m[w - NRW];
      else if (w == P + 1) rd = 32'(stat_m);
      else if (w == P + 2) rd = 32'(en_m);
      else if (w == P + 3) rd = ID;
    end
    if (!err && wr) begin
      if (w < NRW)         ctrl_m[w] = wd;
      else if (w == P)     pulse = wd;
      else if (w == P + 1) stat_m = stat_m & ~wd[NIRQ-1:0];
      else if (w == P + 2) en_m = wd[NIRQ-1:0];
    end
  endfunction

  task automatic set_status();
    for (int k = 0; k < NRO; k++) status_in[32*k +: 32] = stat_in_m[k];
  endtask

  task automatic chk_ctrl(input string nm);
    for (int k = 0; k < NRW; k++) chk(nm, ctrl_out[32*k +: 32], ctrl_m[k]);
  endtask

  // One full transfer; ev_wait is pulsed on irq_event during the WAIT cycle.
  task automatic xfer(input logic [AW-1:0] a, input logic wr, input logic [31:0] wd,
                      input logic [NIRQ-1:0] ev_wait);
    logic err;
    logic [31:0] rd;
    logic [31:0] pexp;
    logic irq_pre;
    int cnt;
    irq_pre = |(stat_m & en_m);
    model_access(a, wr, wd, err, rd, pexp);
    stat_m = stat_m | ev_wait;
    expq.push_back('{d: rd, e: err});
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = wr; PWDATA = wd;
    @(posedge clk); #1;
    cnt = 1;
    PENABLE = 1'b1;
    while (!PREADY && cnt < 10) begin
      @(posedge clk); #1;
      cnt++;
      irq_event = (cnt == 2) ? ev_wait : '0;
    end
    chk("latency", 32'(cnt), 32'd3);
    chk_ctrl("ctrl_done");
    chk("pulse_done", pulse_out, pexp);
    chk("irq_done", {31'd0, irq}, {31'd0, irq_pre});
  endtask

  task automatic idle();
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; irq_event = '0;
  endtask

  task automatic idle_chk();
    idle();
    chk("irq_idle", {31'd0, irq}, {31'd0, |(stat_m & en_m)});
    chk("pulse_idle", pulse_out, 32'd0);
  endtask

  task automatic pulse_ev(input logic [NIRQ-1:0] ev);
    logic irq_pre;
    irq_pre = |(stat_m & en_m);
    irq_event = ev;
    @(posedge clk); #1;
    irq_event = '0;
    stat_m = stat_m | ev;
    chk("irq_lag", {31'd0, irq}, {31'd0, irq_pre});
    @(posedge clk); #1;
    chk("irq_ev", {31'd0, irq}, {31'd0, |(stat_m & en_m)});
  endtask

  task automatic no_ready(input string nm, input int cycles);
    repeat (cycles) begin
      @(posedge clk); #1;
      chk(nm, {31'd0, PREADY}, 32'd0);
    end
  endtask

  // Scoreboard monitor: every PREADY pulse consumes one expected response.
  logic prev_rdy = 1'b0;
  always @(negedge clk) begin
    resp_t r;
    if (PREADY) begin
      chk("pready_width", {31'd0, prev_rdy}, 32'd0);
      if (expq.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_pready: got PREADY=1 expected no transfer");
      end else begin
        r = expq.pop_front();
        chk("prdata", PRDATA, r.d);
        chk("pslverror", {31'd0, PSLVERROR}, {31'd0, r.e});
      end
    end
    prev_rdy = PREADY;
  end

  initial begin
    #500us;
    $display("FAIL timeout: simulation did not finish, got %0d/%0d checks", n_pass, n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    logic [AW-1:0] a;
    int unsigned w;
    for (int k = 0; k < NRO; k++) stat_in_m[k] = '0;
    model_reset();
    set_status();
    resetn = 1'b0;
    irq_event = '1;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    irq_event = '0;
    chk("rst_pready", {31'd0, PREADY}, 32'd0);
    chk("rst_prdata", PRDATA, 32'd0);
    chk("rst_pslverr", {31'd0, PSLVERROR}, 32'd0);
    chk_ctrl("rst_ctrl");
    chk("rst_pulse", pulse_out, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);

    xfer(12'h000, 1'b1, 32'h0000_1234, '0);
    xfer(12'h000, 1'b0, 32'h0, '0);
    idle_chk();

    stat_in_m[0] = 32'hDEAD_BEEF;
    set_status();
    xfer(12'h020, 1'b0, 32'h0, '0);
    xfer(12'h04C, 1'b0, 32'h0, '0);
    xfer(12'h044, 1'b0, 32'h0, '0);

    xfer(12'h020, 1'b1, 32'h5, '0);
    xfer(12'h002, 1'b0, 32'h0, '0);
    xfer(12'h050, 1'b0, 32'h0, '0);
    xfer(12'h04C, 1'b1, 32'h1, '0);
    idle_chk();

    xfer(12'h040, 1'b1, 32'h3, '0);
    idle_chk();
    xfer(12'h040, 1'b0, 32'h0, '0);
    idle_chk();

    xfer(12'h048, 1'b1, 32'h1, '0);
    idle_chk();
    pulse_ev(8'h01);
    xfer(12'h044, 1'b0, 32'h0, '0);
    xfer(12'h044, 1'b1, 32'h1, 8'h01);
    idle_chk();
    xfer(12'h044, 1'b0, 32'h0, '0);
    xfer(12'h044, 1'b1, 32'h1, '0);
    idle_chk();
    xfer(12'h044, 1'b0, 32'h0, '0);
    idle_chk();

    // Reset during the WAIT cycle of a write abandons it.
    xfer(12'h004, 1'b1, 32'h0000_0055, '0);
    idle();
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 12'h004; PWRITE = 1'b1; PWDATA = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    PSEL = 1'b0; PENABLE = 1'b0;
    model_reset();
    chk("rst_mid_ctrl1", ctrl_out[63:32], 32'd0);
    no_ready("rst_mid_pready", 4);
    chk_ctrl("rst_mid_ctrl");

    // PSEL dropped in WAIT aborts with no commit.
    xfer(12'h008, 1'b1, 32'h0000_1111, '0);
    idle();
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 12'h008; PWRITE = 1'b1; PWDATA = 32'h0000_AAAA;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    no_ready("abort_pready", 4);
    chk("abort_ctrl2", ctrl_out[95:64], 32'h0000_1111);
    xfer(12'h008, 1'b0, 32'h0, '0);
    idle_chk();

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        idle_chk();
        if ($urandom_range(0, 3) == 0) pulse_ev(NIRQ'($urandom));
        stat_in_m[$urandom_range(0, NRO - 1)] = $urandom;
        set_status();
      end
      w = $urandom_range(0, P + 5);
      a = AW'(w * 4);
      if ($urandom_range(0, 7) == 0) a = a + AW'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) a = AW'($urandom);
      xfer(a, 1'($urandom_range(0, 1)), $urandom, '0);
    end

    idle_chk();
    repeat (3) idle();
    chk("queue_empty", 32'(expq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
